// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - decode-stage slot tracker producing operand-forwarding selects and write-back address
// Optional load-use interlock: define FWD_LOAD_STALL_EN.
module fwd_hazard_ctrl #(
  parameter int SCRATCH_REG = 31,
  parameter int IW          = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] ins_in,
  input  logic          ins_in_valid,
  output logic [IW-1:0] ins,
  output logic [7:0]    imm,
  output logic          imm_sel,
  output logic [1:0]    mux_sel_A,
  output logic [1:0]    mux_sel_B,
  output logic [4:0]    RW_dm,
  output logic          stall
);

  localparam logic [4:0] SCR = 5'(SCRATCH_REG);

  logic       d_valid;
  logic [1:0] d_cls;
  logic [4:0] d_rd, d_rs1, d_rs2;
  logic       d_writes;

  // E/M/W keep only what forwarding needs: a combined valid&writes bit and rd.
  logic       e_wr, m_wr, w_wr;
  logic [4:0] e_rd, m_rd, w_rd;

  logic [1:0] sel_a, sel_b;

  assign d_cls    = ins[23:22];
  assign d_rd     = ins[18:14];
  assign d_rs1    = ins[13:9];
  assign d_rs2    = ins[8:4];
  assign d_writes = d_valid && (d_cls != 2'b11);

  function automatic logic [1:0] pick(
    input logic [4:0] r,
    input logic       ew, input logic [4:0] erd,
    input logic       mw, input logic [4:0] mrd,
    input logic       ww, input logic [4:0] wrd
  );
    logic [1:0] s;
    s = 2'b00;
    if (r != SCR) begin
      if (ew && erd == r)      s = 2'b01;
      else if (mw && mrd == r) s = 2'b10;
      else if (ww && wrd == r) s = 2'b11;
    end
    return s;
  endfunction

  always_comb begin
    sel_a = 2'b00;
    sel_b = 2'b00;
    if (d_valid) begin
      sel_a = pick(d_rs1, e_wr, e_rd, m_wr, m_rd, w_wr, w_rd);
      if (d_cls != 2'b01)
        sel_b = pick(d_rs2, e_wr, e_rd, m_wr, m_rd, w_wr, w_rd);
    end
  end

`ifdef FWD_LOAD_STALL_EN
  logic e_load;
  logic d_load;
  logic hazard;

  assign d_load = d_valid && (d_cls == 2'b10);
  // rs2 is a real source only for reg-reg ALU and store/branch.
  assign hazard = d_valid && e_load && (e_rd != SCR) &&
                  ((d_rs1 == e_rd) ||
                   (((d_cls == 2'b00) || (d_cls == 2'b11)) && (d_rs2 == e_rd)));
  assign stall  = hazard && !rst;

  always_ff @(posedge clk) begin
    if (rst)
      e_load <= 1'b0;
    else if (stall)
      e_load <= 1'b0;
    else
      e_load <= d_load;
  end
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      d_valid   <= 1'b0;
      ins       <= '0;
      e_wr      <= 1'b0;
      e_rd      <= '0;
      m_wr      <= 1'b0;
      m_rd      <= '0;
      w_wr      <= 1'b0;
      w_rd      <= '0;
      imm       <= '0;
      imm_sel   <= 1'b0;
      mux_sel_A <= 2'b00;
      mux_sel_B <= 2'b00;
      RW_dm     <= SCR;
    end else begin
      w_wr  <= m_wr;
      w_rd  <= m_rd;
      m_wr  <= e_wr;
      m_rd  <= e_rd;
      // Bank writes every cycle, so anything not writing is steered to scratch.
      RW_dm <= e_wr ? e_rd : SCR;
      if (stall) begin
        e_wr      <= 1'b0;
        e_rd      <= '0;
        imm       <= '0;
        imm_sel   <= 1'b0;
        mux_sel_A <= 2'b00;
        mux_sel_B <= 2'b00;
      end else begin
        e_wr      <= d_writes;
        e_rd      <= d_rd;
        imm       <= d_valid ? ins[7:0] : 8'h00;
        imm_sel   <= d_valid && (d_cls == 2'b01);
        mux_sel_A <= sel_a;
        mux_sel_B <= sel_b;
        d_valid   <= ins_in_valid;
        ins       <= ins_in_valid ? ins_in : '0;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed-vector self-checking bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] ins_in;
  logic        ins_in_valid;
  logic [23:0] ins;
  logic [7:0]  imm;
  logic        imm_sel;
  logic [1:0]  mux_sel_A, mux_sel_B;
  logic [4:0]  RW_dm;
  logic        stall;

  int total = 0;
  int bad   = 0;

  fwd_hazard_ctrl dut (
    .clk(clk), .rst(rst), .ins_in(ins_in), .ins_in_valid(ins_in_valid),
    .ins(ins), .imm(imm), .imm_sel(imm_sel), .mux_sel_A(mux_sel_A),
    .mux_sel_B(mux_sel_B), .RW_dm(RW_dm), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [1:0] cls, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {cls, 3'b000, rd, rs1, rs2, 4'b0000};
  endfunction

  function automatic logic [23:0] mk_i(input logic [1:0] cls, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [7:0] im);
    return {cls, 3'b000, rd, rs1, 1'b0, im};
  endfunction

  task automatic step(input logic [23:0] i, input logic v);
    ins_in       = i;
    ins_in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int k = 0; k < 4; k++) step(24'h0, 1'b0);
  endtask

  logic [23:0] filler;
  logic [23:0] c4;
  logic [1:0]  exp_far [0:3];

  initial begin
    filler = mk(2'b11, 5'd0, 5'd1, 5'd2);
    exp_far[0] = 2'b01; exp_far[1] = 2'b10; exp_far[2] = 2'b11; exp_far[3] = 2'b00;
    rst = 1'b1;
    step(24'h0, 1'b0);
    step(24'h0, 1'b0);
    check("rst_rw_dm", 32'(RW_dm), 32'd31);
    check("rst_sel_a", 32'(mux_sel_A), 32'd0);
    check("rst_sel_b", 32'(mux_sel_B), 32'd0);
    check("rst_ins", 32'(ins), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_imm_sel", 32'(imm_sel), 32'd0);
    rst = 1'b0;
    flush();

    // Back-to-back dependency on both sources
    step(mk(2'b00, 5'd3, 5'd1, 5'd2), 1'b1);
    step(mk(2'b00, 5'd8, 5'd3, 5'd3), 1'b1);
    step(24'h0, 1'b0);
    check("b2b_sel_a", 32'(mux_sel_A), 32'd1);
    check("b2b_sel_b", 32'(mux_sel_B), 32'd1);
    check("b2b_rw_dm", 32'(RW_dm), 32'd3);

    // Producer distance 0..3 independent instructions
    for (int n = 0; n < 4; n++) begin
      flush();
      step(mk(2'b00, 5'd5, 5'd1, 5'd2), 1'b1);
      for (int f = 0; f < n; f++) step(filler, 1'b1);
      step(mk(2'b00, 5'd9, 5'd5, 5'd0), 1'b1);
      step(24'h0, 1'b0);
      check($sformatf("dist%0d_sel_a", n), 32'(mux_sel_A), 32'(exp_far[n]));
      check($sformatf("dist%0d_sel_b", n), 32'(mux_sel_B), 32'd0);
    end

    // rd 7 in both E and W: nearest wins; store in M redirects write
    flush();
    step(mk(2'b00, 5'd7, 5'd1, 5'd2), 1'b1);
    step(filler, 1'b1);
    step(mk(2'b00, 5'd7, 5'd1, 5'd2), 1'b1);
    check("a7_in_m_rw_dm", 32'(RW_dm), 32'd7);
    step(mk(2'b00, 5'd10, 5'd7, 5'd7), 1'b1);
    check("store_in_m_rw_dm", 32'(RW_dm), 32'd31);
    step(24'h0, 1'b0);
    check("nearest_sel_a", 32'(mux_sel_A), 32'd1);
    check("nearest_sel_b", 32'(mux_sel_B), 32'd1);

    // Scratch register never forwards
    flush();
    step(mk(2'b00, 5'd31, 5'd1, 5'd2), 1'b1);
    step(mk(2'b00, 5'd12, 5'd31, 5'd31), 1'b1);
    step(24'h0, 1'b0);
    check("scratch_sel_a", 32'(mux_sel_A), 32'd0);
    check("scratch_sel_b", 32'(mux_sel_B), 32'd0);

    // Load-use
    flush();
    c4 = mk(2'b00, 5'd11, 5'd4, 5'd0);
    step(mk(2'b10, 5'd4, 5'd1, 5'd0), 1'b1);
    step(c4, 1'b1);
`ifdef FWD_LOAD_STALL_EN
    check("lu_stall_on", 32'(stall), 32'd1);
    step(c4, 1'b1);
    check("lu_stall_off", 32'(stall), 32'd0);
    check("lu_bubble_sel_a", 32'(mux_sel_A), 32'd0);
    check("lu_held_ins", 32'(ins), 32'(c4));
    step(24'h0, 1'b0);
    check("lu_sel_a", 32'(mux_sel_A), 32'd2);
`else
    check("lu_stall_off", 32'(stall), 32'd0);
    step(24'h0, 1'b0);
    check("lu_sel_a", 32'(mux_sel_A), 32'd1);
`endif

    // Immediate class, then reset while it sits in M
    flush();
    step(mk_i(2'b01, 5'd6, 5'd1, 8'hA5), 1'b1);
    step(24'h0, 1'b0);
    check("imm_sel", 32'(imm_sel), 32'd1);
    check("imm_val", 32'(imm), 32'hA5);
    check("imm_sel_b", 32'(mux_sel_B), 32'd0);
    step(24'h0, 1'b0);
    check("imm_rw_dm", 32'(RW_dm), 32'd6);
    rst = 1'b1;
    step(24'h0, 1'b0);
    check("mid_rst_rw_dm", 32'(RW_dm), 32'd31);
    check("mid_rst_imm_sel", 32'(imm_sel), 32'd0);
    check("mid_rst_ins", 32'(ins), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(24'h0, 1'b0);
      check($sformatf("post_rst_rw_dm%0d", k), 32'(RW_dm), 32'd31);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
